// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_cmd_sequencer: HD44780 8-bit write sequencer (power-up, init ROM,    |
// | per-byte setup/enable/wait timing). Option macro: LCD_SEQ_INIT_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_cmd_sequencer #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 25,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int LONG_WAIT_CYC  = 100000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int MAX_A   = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
  localparam int MAX_B   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_C   = (MAX_B > SHORT_WAIT_CYC) ? MAX_B : SHORT_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PWR_LD   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYC - 1);

  localparam logic [2:0] ST_PWRUP = 3'd0;
`ifdef LCD_SEQ_INIT_EN
  localparam logic [2:0] ST_INIT_LOAD = 3'd1;
`endif
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_IDLE  = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          long_wait;

`ifdef LCD_SEQ_INIT_EN
  logic [2:0] k;
  logic       init_active;
  logic [7:0] rom_byte;

  always_comb begin
    rom_byte = 8'h30;
    case (k)
      3'd0:    rom_byte = 8'h30;
      3'd1:    rom_byte = 8'h30;
      3'd2:    rom_byte = 8'h30;
      3'd3:    rom_byte = 8'h38;
      3'd4:    rom_byte = 8'h08;
      3'd5:    rom_byte = 8'h01;
      3'd6:    rom_byte = 8'h06;
      default: rom_byte = 8'h0C;
    endcase
  end
`endif

  // Clear/home (0x01..0x03) need the long execution wait, as do the first two wake-up writes.
  always_comb begin
    long_wait = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);
`ifdef LCD_SEQ_INIT_EN
    if (init_active && (k < 3'd2)) long_wait = 1'b1;
`endif
  end

  assign lcd_rw = 1'b0;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= ST_PWRUP;
      cnt         <= PWR_LD;
      lcd_en      <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      req_ready   <= 1'b0;
      init_done   <= 1'b0;
`ifdef LCD_SEQ_INIT_EN
      k           <= 3'd0;
      init_active <= 1'b0;
`endif
    end else begin
      case (state)
        ST_PWRUP: begin
          if (cnt == '0) begin
`ifdef LCD_SEQ_INIT_EN
            state       <= ST_INIT_LOAD;
            init_active <= 1'b1;
`else
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            init_done   <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef LCD_SEQ_INIT_EN
        ST_INIT_LOAD: begin
          lcd_rs   <= 1'b0;
          lcd_data <= rom_byte;
          cnt      <= SETUP_LD;
          state    <= ST_SETUP;
        end
`endif
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= EN_LD;
            state  <= ST_PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= long_wait ? LONG_LD : SHORT_LD;
            state  <= ST_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
`ifdef LCD_SEQ_INIT_EN
          end else if (init_active && (k != 3'd7)) begin
            k     <= k + 3'd1;
            state <= ST_INIT_LOAD;
`endif
          end else begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
`ifdef LCD_SEQ_INIT_EN
            init_active <= 1'b0;
`endif
          end
        end
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lcd_rs    <= req_rs;
            lcd_data  <= req_data;
            cnt       <= SETUP_LD;
            req_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        default: begin
          state     <= ST_PWRUP;
          cnt       <= PWR_LD;
          lcd_en    <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// Testbench for lcd_cmd_sequencer: scoreboard of expected bus writes checked at each en pulse.
module tb_lcd_cmd_sequencer;

  localparam int PW = 20;
  localparam int S  = 2;
  localparam int E  = 3;
  localparam int SW = 5;
  localparam int LW = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, busy, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  lcd_cmd_sequencer #(
    .POWERUP_CYC(PW), .SETUP_CYC(S), .EN_CYC(E),
    .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW)
  ) dut (
    .clk_clk(clk), .reset_reset(rst),
    .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         pass_cnt = 0;
  int         total = 0;
  int         pulse_cnt = 0;
  int         en_len = 0;
  logic       prev_en = 1'b0;
  logic       skip_len = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;
  int         rises[$];
  int         falls[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor: every en rise pops the scoreboard, every en fall checks pulse width.
  initial forever begin
    @(negedge clk);
    if (lcd_en && !prev_en) begin
      pulse_cnt++;
      rises.push_back(cyc);
      en_len = 1;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got rs=%0d data=%02h, required no pulse", lcd_rs, lcd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({lcd_rs, lcd_data} !== mon_exp)
          $display("FAIL pulse_payload: got rs=%0d data=%02h, required rs=%0d data=%02h",
                   lcd_rs, lcd_data, mon_exp[8], mon_exp[7:0]);
        else pass_cnt++;
      end
    end else if (lcd_en) begin
      en_len++;
    end else if (prev_en) begin
      falls.push_back(cyc);
      if (skip_len) begin
        skip_len = 1'b0;
      end else begin
        total++;
        if (en_len !== E) $display("FAIL en_width: got %0d, required %0d", en_len, E);
        else pass_cnt++;
      end
    end
    prev_en = lcd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      total++;
      $display("FAIL ready_timeout: got req_ready=0, required 1 within 400 cycles");
    end
  endtask

  // Called at the negedge right after reset is released; checks the power-up window and init.
  task automatic check_powerup();
    bit held_ok = 1'b1;
    int rel = cyc;
    int r0 = rises.size();
    int f0 = falls.size();
    int p0 = pulse_cnt;
    int n = 0;
    int w;
`ifdef LCD_SEQ_INIT_EN
    logic [7:0] rom[8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, rom[i]});
`endif
    for (int i = 0; i < PW; i++) begin
      if (!(lcd_en === 1'b0 && lcd_rs === 1'b0 && lcd_rw === 1'b0 && lcd_data === 8'h00 &&
            req_ready === 1'b0 && busy === 1'b1 && init_done === 1'b0)) held_ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!held_ok) $display("FAIL powerup_hold: got outputs changed within %0d cycles, required reset values", PW);
    else pass_cnt++;
`ifdef LCD_SEQ_INIT_EN
    while (!init_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pulse_cnt - p0 !== 8) $display("FAIL init_pulses: got %0d, required 8", pulse_cnt - p0);
    else pass_cnt++;
    if (rises.size() >= r0 + 8 && falls.size() >= f0 + 8) begin
      total++;
      if (rises[r0] - rel !== PW + 1 + S)
        $display("FAIL init_first_en: got %0d, required %0d", rises[r0] - rel, PW + 1 + S);
      else pass_cnt++;
      // Low time between init pulses = wait + one load cycle + setup.
      for (int i = 0; i < 7; i++) begin
        w = (i == 0 || i == 1 || i == 5) ? LW : SW;
        total++;
        if (rises[r0+i+1] - falls[f0+i] - 1 - S !== w)
          $display("FAIL init_gap%0d: got %0d, required %0d", i, rises[r0+i+1] - falls[f0+i] - 1 - S, w);
        else pass_cnt++;
      end
    end
    total++;
    if (init_done !== 1'b1 || req_ready !== 1'b1)
      $display("FAIL init_complete: got init_done=%0d ready=%0d, required 1/1", init_done, req_ready);
    else pass_cnt++;
`else
    total++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL powerup_done: got init_done=%0d ready=%0d busy=%0d at cycle %0d, required 1/1/0",
               init_done, req_ready, busy, cyc - rel);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    total++;
    if (pulse_cnt !== p0) $display("FAIL no_auto_pulse: got %0d pulses, required 0", pulse_cnt - p0);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data, req_ready, busy, init_done} !== {3'b000, 8'h00, 3'b010})
      $display("FAIL reset_values: got en=%0d rs=%0d rw=%0d data=%02h ready=%0d busy=%0d done=%0d, required 0/0/0/00/0/1/0",
               lcd_en, lcd_rs, lcd_rw, lcd_data, req_ready, busy, init_done);
    else pass_cnt++;
    rst = 1'b0;
    check_powerup();
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input int w, input string name);
    bit ok;
    int a;
    int n = 0;
    int r0;
    wait_ready(ok);
    if (!ok) return;
    r0 = rises.size();
    req_valid = 1'b1;
    req_rs = rs;
    req_data = d;
    exp_q.push_back({rs, d});
    @(negedge clk);
    req_valid = 1'b0;
    a = cyc;
    total++;
    if ({lcd_rs, lcd_data} !== {rs, d})
      $display("FAIL %s_capture: got rs=%0d data=%02h, required rs=%0d data=%02h", name, lcd_rs, lcd_data, rs, d);
    else pass_cnt++;
    while (!req_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== S + E + w) $display("FAIL %s_ready_low: got %0d, required %0d", name, n, S + E + w);
    else pass_cnt++;
    total++;
    if (rises.size() !== r0 + 1) $display("FAIL %s_pulse_count: got %0d, required 1", name, rises.size() - r0);
    else if (rises[r0] - a !== S) $display("FAIL %s_en_start: got %0d, required %0d", name, rises[r0] - a, S);
    else pass_cnt++;
  endtask

  task automatic test_data_write();
    send(1'b1, 8'h41, SW, "data41");
  endtask

  task automatic test_commands();
    send(1'b0, 8'h01, LW, "cmd01");
    send(1'b0, 8'h80, SW, "cmd80");
    send(1'b0, 8'h02, LW, "cmd02");
    send(1'b0, 8'h03, LW, "cmd03");
    send(1'b0, 8'h04, SW, "cmd04");
    send(1'b0, 8'h00, SW, "cmd00");
    send(1'b1, 8'h01, SW, "data01");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int a1, a2;
    int n = 0;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h41;
    exp_q.push_back({1'b1, 8'h41});
    @(negedge clk);
    a1 = cyc;
    req_data = 8'h42;
    exp_q.push_back({1'b1, 8'h42});
    while (!req_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    a2 = cyc;
    req_valid = 1'b0;
    total++;
    if (a2 - a1 !== S + E + SW + 1) $display("FAIL b2b_spacing: got %0d, required %0d", a2 - a1, S + E + SW + 1);
    else pass_cnt++;
    total++;
    if (lcd_data !== 8'h42) $display("FAIL b2b_second: got %02h, required 42", lcd_data);
    else pass_cnt++;
    wait_ready(ok);
  endtask

  task automatic test_ignore_busy();
    bit ok;
    int p0;
    wait_ready(ok);
    if (!ok) return;
    p0 = pulse_cnt;
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h55;
    exp_q.push_back({1'b1, 8'h55});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      req_data = 8'h66;
      @(negedge clk);
      req_valid = 1'b0;
    end
    wait_ready(ok);
    repeat (15) @(negedge clk);
    total++;
    if (pulse_cnt - p0 !== 1 || req_ready !== 1'b1 || exp_q.size() !== 0)
      $display("FAIL busy_ignore: got pulses=%0d ready=%0d pending=%0d, required 1/1/0",
               pulse_cnt - p0, req_ready, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse();
    bit ok;
    int n = 0;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_rs = 1'b1;
    req_data = 8'h5A;
    exp_q.push_back({1'b1, 8'h5A});
    @(negedge clk);
    req_valid = 1'b0;
    while (!lcd_en && n < 50) begin
      n++;
      @(negedge clk);
    end
    skip_len = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({lcd_en, lcd_rs, lcd_data, init_done, req_ready, busy} !== {2'b00, 8'h00, 3'b001})
      $display("FAIL reset_mid_pulse: got en=%0d rs=%0d data=%02h done=%0d ready=%0d busy=%0d, required 0/0/00/0/0/1",
               lcd_en, lcd_rs, lcd_data, init_done, req_ready, busy);
    else pass_cnt++;
    rst = 1'b0;
    check_powerup();
    send(1'b1, 8'h43, SW, "post_reset");
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_commands();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_pulse();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
